// File: rtl/sha1_pkg.sv
// Shared types and elaboration helpers for the SHA1 job dispatch front-end.
package sha1_pkg;

  localparam int DEF_TAG_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Outstanding credits can never exceed the tag space, or live tags would alias.
  function automatic bit credit_fits(input int max_out, input int tag_w);
    return longint'(max_out) <= (longint'(1) << tag_w);
  endfunction

endpackage

// File: rtl/sha1_rr_arb.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap.
module sha1_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha1_tag_dispatch.sv
// Tags incoming hash jobs, dispatches them round-robin to idle SHA1 engines,
// and limits outstanding tags to the reorder buffer depth.
module sha1_tag_dispatch
  import sha1_pkg::*;
#(
  parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter int NUM_ENG         = 4,
  parameter int MAX_OUTSTANDING = 1024,
  parameter int ENG_IDX_W       = $clog2(NUM_ENG),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic                 job_valid,
  output logic                 job_ready,
  output logic [TAG_WIDTH-1:0] job_tag,
  input  logic [NUM_ENG-1:0]   eng_idle,
  output logic [NUM_ENG-1:0]   eng_start,
  output logic [TAG_WIDTH-1:0] eng_tag,
  output logic [ENG_IDX_W-1:0] eng_idx,
  input  logic                 rel_en,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err_underflow
);

  if (!credit_fits(MAX_OUTSTANDING, TAG_WIDTH)) begin : g_credit_check
    $error("MAX_OUTSTANDING exceeds the tag space");
  end

  state_t                 state, state_nxt;
  logic [TAG_WIDTH-1:0]   next_tag;
  logic [ENG_IDX_W-1:0]   rr_ptr;
  logic [ENG_IDX_W-1:0]   arb_idx;
  logic                   arb_valid;
  logic                   credit_ok;
  logic                   accept;

  sha1_rr_arb #(
    .N     (NUM_ENG),
    .IDX_W (ENG_IDX_W)
  ) u_arb (
    .req       (eng_idle),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign credit_ok = outstanding < CNT_W'(MAX_OUTSTANDING);
  assign accept    = job_valid & job_ready;
  assign job_tag   = next_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    case (state)
      ST_INIT:  if (init_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        job_ready = arb_valid & credit_ok;
        if (job_valid & job_ready) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_HOLD;
      ST_HOLD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // The start pulse is registered at accept so it lands exactly in ST_ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_start     <= '0;
      eng_tag       <= '0;
      eng_idx       <= '0;
      next_tag      <= '0;
      rr_ptr        <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      eng_start <= '0;
      if (accept) begin
        eng_start <= NUM_ENG'(1) << arb_idx;
        eng_idx   <= arb_idx;
        eng_tag   <= next_tag;
      end
      if (state == ST_ISSUE) begin
        next_tag <= next_tag + 1'b1;
        rr_ptr   <= (eng_idx == ENG_IDX_W'(NUM_ENG - 1)) ? '0 : eng_idx + 1'b1;
      end
      if (accept && !rel_en)
        outstanding <= outstanding + 1'b1;
      else if (!accept && rel_en && outstanding != '0)
        outstanding <= outstanding - 1'b1;
      if (rel_en && outstanding == '0)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/sha1_tag_dispatch.md
# sha1_tag_dispatch

Front-end scheduler for the SHA1 engine array. It accepts hash jobs from the packet parser and assigns each one a sequential tag. Each job goes to a free engine, picked round-robin. The block caps the number of outstanding tags at the depth of the result reorder buffer, and each tag is credited back when its ordered result is popped. It sits between the parser and the engines, and pairs with the reorder buffer that consumes the tags.

## Interface
Parameters:
- TAG_WIDTH, 10, width of the job tag; tags count modulo 2^TAG_WIDTH
- NUM_ENG, 4, number of SHA1 engines (2..16)
- MAX_OUTSTANDING, 1024, credit limit; must be ≤ 2^TAG_WIDTH and equal to the reorder RAM depth
- ENG_IDX_W, $clog2(NUM_ENG), engine index width
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low. Clock is clk.
- init_done  in  1  reorder buffer RAM initialisation complete
- job_valid  in  1  parser has a job
- job_ready  out  1  job accepted on the edge where job_valid & job_ready
- job_tag  out  TAG_WIDTH  tag the next accepted job receives; stable while job_ready=1
- eng_idle  in  NUM_ENG  per-engine free flag
- eng_start  out  NUM_ENG  one-hot, single-cycle start pulse
- eng_tag  out  TAG_WIDTH  tag sent with eng_start
- eng_idx  out  ENG_IDX_W  index of the started engine
- rel_en  in  1  one tag retired (reorder buffer pop)
- outstanding  out  CNT_W  tags issued and not yet retired
- err_underflow  out  1  sticky; rel_en seen while outstanding==0

## Operation
- States: ST_INIT, ST_IDLE, ST_ISSUE, ST_HOLD.
- ST_INIT: job_ready=0. Move to ST_IDLE on the first cycle init_done=1.
- ST_IDLE: job_ready = any_eligible & (outstanding < MAX_OUTSTANDING), where any_eligible = |eng_idle.
  - On accept: latch the grant g, the first idle engine searching upward from rr_ptr with wrap. Latch tag = next_tag. Go to ST_ISSUE.
- ST_ISSUE: eng_start[g]=1, eng_tag=latched tag, eng_idx=g, all for exactly one cycle. Then:
  - next_tag ← next_tag+1, wrapping 2^TAG_WIDTH-1 → 0.
  - rr_ptr ← (g+1) mod NUM_ENG.
  - Go to ST_HOLD.
- ST_HOLD: one dead cycle so the engine can drop eng_idle. Then go to ST_IDLE.
- outstanding:
  - +1 on accept, -1 on rel_en; both in the same cycle leaves it unchanged.
  - rel_en at 0 leaves the count at 0 and sets err_underflow.
- init_done dropping after ST_INIT is ignored.
- Unreachable state encodings recover to ST_INIT.

## Timing
- Reset values:
  - job_ready=0, job_tag=0, eng_start=0, eng_tag=0, eng_idx=0
  - outstanding=0, err_underflow=0, next_tag=0, rr_ptr=0, state=ST_INIT
- Reset mid-operation discards all in-flight bookkeeping; the tag restarts at 0. The reorder buffer must be reset with this block.
- Accept at edge T:
  - eng_start high during cycle T+1 only.
  - job_ready low during T+1 and T+2; it may reassert in T+3.
  - Peak rate is one job per 3 cycles.
- outstanding updates on the edge after accept or rel_en and is a registered output.
- job_ready is combinational from state, eng_idle and outstanding. job_valid must not depend on job_ready.
- All other outputs are registered.
- Credit full: at outstanding == MAX_OUTSTANDING, job_ready=0. A rel_en in that cycle allows ready in the next cycle, not the same cycle.

## Structure
- sha1_pkg holds the FSM state enum, the default TAG_WIDTH, and a MAX_OUTSTANDING consistency check (elaboration-time $error if MAX_OUTSTANDING > 2^TAG_WIDTH).
- Sub-module sha1_rr_arb: combinational round-robin picker. Inputs are req[NUM_ENG] and ptr. Outputs are gnt_idx and gnt_valid. It is reusable for result-collection arbitration.

## Test plan
- Reset then init_done at cycle 5, job_valid held, all engines idle → no eng_start before cycle 6. Starts go to engines 0,1,2,3,0 with tags 0,1,2,3,4, spaced 3 cycles apart.
- eng_idle=4'b1010, rr_ptr=0 → grant to engine 1, then engine 3; engines 0 and 2 are never started.
- MAX_OUTSTANDING=4, no rel_en → four jobs accepted, then job_ready=0. A single rel_en pulse → exactly one more accept; outstanding reads 4.
- Accept and rel_en in the same cycle at outstanding=2 → outstanding stays 2.
- TAG_WIDTH=3 with continuous release, 10 jobs → tags 0..7, 0, 1.
- rel_en at outstanding=0 → err_underflow=1 and held; outstanding=0.
- Assert rst_n=0 during ST_ISSUE → next cycle eng_start=0, outstanding=0, state ST_INIT, next job gets tag 0.
